// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared state encoding and distance scaling for the HC-SR04 ranging controller
package hcsr04_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE,
    S_HOLDOFF
  } state_e;
  localparam int unsigned DIST_SCALE = 11239;
  localparam int unsigned DIST_SHIFT = 16;
  // Echo microseconds to millimetres: 11239/65536 ~= 0.1715 mm/us (half the speed of sound)
  function automatic logic [15:0] us_to_mm(input logic [15:0] us);
    logic [31:0] p;
    p = 32'(us) * 32'(DIST_SCALE);
    return 16'(p >> DIST_SHIFT);
  endfunction
endpackage

// File: rtl/hcsr04_us_tick_gen.sv
// us_tick_gen: 1 us tick prescaler counting 0..CLKS_PER_US-1, restartable by clr
// Ports: clk, rst (async active-high), clr (restart count at 0), tick (high on last count).
module us_tick_gen #(
  parameter int unsigned CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(CLKS_PER_US - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/hcsr04_range_ctrl.sv
// hcsr04_range_ctrl: HC-SR04 trigger/echo sequencer producing distance in mm
// Ports: clk, rst (async active-high), start (one-shot, IDLE only), auto_en (free-run),
//        echo (async sensor input), trig, busy, dist_valid (1-cycle), dist_mm[15:0], timeout (1-cycle).
// Build option ECHO_DEGLITCH_EN: echo_s follows the synchronized echo only after 4 stable clocks.
module hcsr04_range_ctrl
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned RISE_TO_US  = 2000,
  parameter int unsigned ECHO_TO_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        dist_valid,
  output logic [15:0] dist_mm,
  output logic        timeout
);
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0] RISE_LAST = 16'(RISE_TO_US - 1);
  localparam logic [15:0] ECHO_LAST = 16'(ECHO_TO_US - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_US - 1);
  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, echo_s, echo_prev_q;
  logic [15:0] us_cnt_q, us_cnt_d, dist_q, dist_d;
  logic        timeout_q, timeout_d;
  logic        tick, clr, rise, fall;
  us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );
`ifdef ECHO_DEGLITCH_EN
  logic       echo_f_q, echo_f_d;
  logic [1:0] gl_q, gl_d;
  // gl counts clocks the synchronized echo disagrees with echo_f; wraps to 0 on the accepting clock
  always_comb begin
    gl_d     = (sync2_q == echo_f_q) ? 2'd0 : gl_q + 2'd1;
    echo_f_d = (sync2_q != echo_f_q && gl_q == 2'd3) ? sync2_q : echo_f_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gl_q     <= '0;
      echo_f_q <= 1'b0;
    end else begin
      gl_q     <= gl_d;
      echo_f_q <= echo_f_d;
    end
  assign echo_s = echo_f_q;
`else
  assign echo_s = sync2_q;
`endif
  always_comb begin
    rise      = echo_s & ~echo_prev_q;
    fall      = ~echo_s & echo_prev_q;
    state_d   = state_q;
    dist_d    = dist_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE:      if (start || auto_en) state_d = S_TRIG;
      S_TRIG:      if (tick && us_cnt_q == TRIG_LAST) state_d = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (rise) state_d = S_MEASURE;
        else if (tick && us_cnt_q == RISE_LAST) begin
          state_d   = S_HOLDOFF;
          timeout_d = 1'b1;
        end
      end
      S_MEASURE: begin
        // The tick landing on the fall cycle still counts, so echo_us = floor(high_clocks / CLKS_PER_US)
        if (fall) begin
          state_d = S_DONE;
          dist_d  = us_to_mm(us_cnt_q + 16'(tick));
        end else if (tick && us_cnt_q == ECHO_LAST) begin
          state_d   = S_HOLDOFF;
          timeout_d = 1'b1;
        end
      end
      S_DONE:      state_d = S_HOLDOFF;
      S_HOLDOFF:   if (tick && us_cnt_q == HOLD_LAST) state_d = auto_en ? S_TRIG : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    clr      = state_d != state_q;
    us_cnt_d = clr ? '0 : us_cnt_q + 16'(tick);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      echo_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      us_cnt_q    <= '0;
      dist_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      sync1_q     <= echo;
      sync2_q     <= sync1_q;
      echo_prev_q <= echo_s;
      state_q     <= state_d;
      us_cnt_q    <= us_cnt_d;
      dist_q      <= dist_d;
      timeout_q   <= timeout_d;
    end
  assign trig       = state_q == S_TRIG;
  assign busy       = state_q != S_IDLE;
  assign dist_valid = state_q == S_DONE;
  assign dist_mm    = dist_q;
  assign timeout    = timeout_q;
endmodule

// File: tb/tb_hcsr04_range_ctrl.sv
// tb_hcsr04_range_ctrl: randomized self-checking bench against a cycle-timeline model of the ranging controller
module tb_hcsr04_range_ctrl;
  localparam int N    = 50;
  localparam int TUS  = 10;
  localparam int RUS  = 20;
  localparam int EUS  = 60;
  localparam int HUS  = 10;
  localparam int TC   = TUS * N;
  localparam int RC   = RUS * N;
  localparam int EC   = EUS * N;
  localparam int HC   = HUS * N;
  localparam int MAXC = 90000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, auto_en = 1'b0, echo = 1'b0;
  logic trig, busy, dist_valid, timeout;
  logic [15:0] dist_mm;
  bit exp_trig[MAXC], exp_busy[MAXC], exp_dv[MAXC], exp_to[MAXC];
  bit [15:0] exp_dist[MAXC];
  int cyc = 0, n_chk = 0, n_err = 0;
  int tw = 0, last_tw = 0, fall_cyc = 0, rise_last = 0, rise_prev = 0, n_dv = 0, n_to = 0, last_to = 0;
  logic trig_p = 1'b0;
  hcsr04_range_ctrl #(
    .CLKS_PER_US(N), .TRIG_US(TUS), .RISE_TO_US(RUS), .ECHO_TO_US(EUS), .HOLDOFF_US(HUS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .echo(echo),
    .trig(trig), .busy(busy), .dist_valid(dist_valid), .dist_mm(dist_mm), .timeout(timeout)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic check(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask
  function automatic int dist_fn(input int us);
    bit [31:0] p;
    p = 32'(us) * 32'd11239;
    return int'(p[31:16]);
  endfunction
  // Model: from trigger cycle, echo delay d (clocks after trig falls; -1 none, -2 already high) and
  // echo width h (clocks), lay down the expected per-cycle outputs and return the first cycle after HOLDOFF.
  task automatic plan(input int ct, input int d, input int h, output int nx);
    int t, m, hs;
    t = ct + TC;
    for (int c = ct; c < t; c++) exp_trig[c] = 1'b1;
    if (d >= 0 && d + 2 <= RC - 1) begin
      m = t + d + 3;
      if (h <= EC) begin
        exp_dv[m + h] = 1'b1;
        for (int c = m + h; c < MAXC; c++) exp_dist[c] = 16'(dist_fn(h / N));
        hs = m + h + 1;
      end else begin
        hs = m + EC;
        exp_to[hs] = 1'b1;
      end
    end else begin
      hs = t + RC;
      exp_to[hs] = 1'b1;
    end
    for (int c = ct; c < hs + HC; c++) exp_busy[c] = 1'b1;
    nx = hs + HC;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic run_ep(input int ct, input int d, input int h, output int nx);
    plan(ct, d, h, nx);
    wait_until(ct);
    start = 1'b0;
    wait_until(ct + 3);
    start = 1'b1;
    wait_until(ct + 4);
    start = 1'b0;
    if (d >= 0) begin
      wait_until(ct + TC + d);
      echo = 1'b1;
      wait_until(ct + TC + d + h);
      echo = 1'b0;
    end else if (d == -2) begin
      wait_until(ct + 5);
      echo = 1'b1;
      wait_until(ct + TC + RC + 20);
      echo = 1'b0;
    end
    wait_until(cyc + 2);
    start = 1'b1;
    wait_until(cyc + 1);
    start = 1'b0;
  endtask
  task automatic manual(input int d, input int h);
    int nx;
    wait_until(cyc + 2);
    start = 1'b1;
    run_ep(cyc + 1, d, h, nx);
    wait_until(nx + 2);
  endtask
  initial forever begin
    @(negedge clk);
    if (cyc < MAXC) begin
      check("trig", int'(trig), int'(exp_trig[cyc]));
      check("busy", int'(busy), int'(exp_busy[cyc]));
      check("dist_valid", int'(dist_valid), int'(exp_dv[cyc]));
      check("timeout", int'(timeout), int'(exp_to[cyc]));
      check("dist_mm", int'(dist_mm), int'(exp_dist[cyc]));
      if (dist_valid || timeout) check("dv_to_exclusive", int'(dist_valid & timeout), 0);
    end
  end
  initial forever begin
    @(negedge clk);
    if (trig && !trig_p) begin
      rise_prev = rise_last;
      rise_last = cyc;
    end
    if (trig) tw++;
    if (!trig && trig_p) begin
      last_tw  = tw;
      tw       = 0;
      fall_cyc = cyc;
    end
    if (dist_valid) n_dv++;
    if (timeout) begin
      n_to++;
      last_to = cyc;
    end
    trig_p = trig;
  end
  initial begin
    #(10 * (MAXC - 100));
    $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int nx, ct, dv0, to0, d, h;
    int len[3];
    repeat (4) @(negedge clk);
    check("rst_trig", int'(trig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dv", int'(dist_valid), 0);
    check("rst_to", int'(timeout), 0);
    check("rst_dist", int'(dist_mm), 0);
    rst = 1'b0;
    check("model_mm_1000us", dist_fn(1000), 171);
    check("model_mm_2915us", dist_fn(2915), 499);
    manual(15 * N, 59 * N + 7);
    check("trig_width", last_tw, 500);
    check("dist_ep1", int'(dist_mm), 10);
    check("idle_busy", int'(busy), 0);
    manual(-1, 0);
    check("rise_timeout_delay", last_to - fall_cyc, 1000);
    check("dist_kept", int'(dist_mm), 10);
    dv0 = n_dv;
    to0 = n_to;
    manual(-2, 0);
    check("stuck_no_dv", n_dv - dv0, 0);
    check("stuck_timeout", n_to - to0, 1);
    dv0 = n_dv;
    manual(10 * N, EC + 200);
    check("echo_timeout_delay", last_to - fall_cyc, 3503);
    check("long_echo_no_dv", n_dv - dv0, 0);
    check("long_echo_dist_kept", int'(dist_mm), 10);
    manual(7, EC);
    check("dist_echo_limit", int'(dist_mm), 10);
    dv0 = n_dv;
    manual(RC - 3, 2 * N);
    check("late_rise_dv", n_dv - dv0, 1);
    to0 = n_to;
    manual(RC - 2, 100);
    check("too_late_rise_to", n_to - to0, 1);
    repeat (4) manual($urandom_range(RC - 3, 0), $urandom_range(EC, 1));
    dv0 = n_dv;
    wait_until(cyc + 2);
    auto_en = 1'b1;
    ct = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(500, 0);
      h = $urandom_range(2000, 1);
      run_ep(ct, d, h, nx);
      if (i == 2) auto_en = 1'b0;
      len[i] = nx - ct;
      ct = nx;
    end
    wait_until(nx + 2);
    check("auto_spacing", rise_last - rise_prev, len[1]);
    check("auto_dv_count", n_dv - dv0, 3);
    check("auto_idle", int'(busy), 0);
    wait_until(cyc + 2);
    start = 1'b1;
    ct = cyc + 1;
    plan(ct, 5 * N, 40 * N, nx);
    wait_until(ct);
    start = 1'b0;
    wait_until(ct + TC + 5 * N);
    echo = 1'b1;
    wait_until(ct + TC + 5 * N + 3 + 200);
    dv0 = n_dv;
    to0 = n_to;
    check("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    for (int c = cyc + 1; c < MAXC; c++) begin
      exp_trig[c] = 1'b0;
      exp_busy[c] = 1'b0;
      exp_dv[c]   = 1'b0;
      exp_to[c]   = 1'b0;
      exp_dist[c] = '0;
    end
    #1;
    check("midrst_trig", int'(trig), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dv", int'(dist_valid), 0);
    check("midrst_to", int'(timeout), 0);
    check("midrst_dist", int'(dist_mm), 0);
    echo = 1'b0;
    wait_until(cyc + 3);
    rst = 1'b0;
    wait_until(cyc + 20);
    check("midrst_no_dv", n_dv - dv0, 0);
    check("midrst_no_to", n_to - to0, 0);
    manual(20, 30 * N + 13);
    check("fresh_dist", int'(dist_mm), 5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hcsr04_range_ctrl.md
HCSR04_RANGE_CTRL -- requirements
Module: hcsr04_range_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 50: clock cycles per microsecond at the 50 MHz system clock.
REQ-002 SHALL have parameter TRIG_US, default 10: trig pulse width, in us.
REQ-003 SHALL have parameter RISE_TO_US, default 2000: maximum wait from trig fall to echo rise, in us.
REQ-004 SHALL have parameter ECHO_TO_US, default 38000: maximum echo high time, in us.
REQ-005 SHALL have parameter HOLDOFF_US, default 60000: minimum gap after each cycle, in us.
REQ-006 SHALL have ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-shot request, sampled in IDLE only.
- auto_en  in  1  1 = re-trigger automatically after HOLDOFF.
- echo  in  1  sensor echo, asynchronous to clk.
- trig  out  1  sensor trigger.
- busy  out  1  high in every state except IDLE.
- dist_valid  out  1  one-cycle pulse when dist_mm updates.
- dist_mm  out  16  last measured distance, in mm.
- timeout  out  1  one-cycle pulse when a cycle aborts.

Function
REQ-007 SHALL pass echo through a 2-flop synchronizer; edge detection uses the synchronized signal (echo_s).
REQ-008 SHALL generate a 1 us tick from a prescaler counting 0..CLKS_PER_US-1; the prescaler and the 16-bit us counter clear on every state transition.
REQ-009 SHALL implement the states IDLE, TRIG, WAIT_RISE, MEASURE, DONE and HOLDOFF.
REQ-010 IDLE -> TRIG when start=1 or auto_en=1; trig SHALL be high the cycle after that sample.
REQ-011 trig SHALL be high in TRIG only, for exactly TRIG_US*CLKS_PER_US cycles; then -> WAIT_RISE.
REQ-012 WAIT_RISE -> MEASURE on a rising edge of echo_s.
- WAIT_RISE -> HOLDOFF with a timeout pulse when the us counter reaches RISE_TO_US.
- A stuck-high echo (no edge) SHALL therefore time out.
REQ-013 MEASURE SHALL count us ticks while echo_s=1.
- On the falling edge -> DONE.
- On count = ECHO_TO_US -> HOLDOFF with a timeout pulse, and dist_mm unchanged.
REQ-014 DONE SHALL last one cycle and set dist_mm = (echo_us * 11239) >> 16, using a 32-bit product truncated to 16 bits; dist_valid=1 that cycle; then -> HOLDOFF.
REQ-015 HOLDOFF SHALL last HOLDOFF_US us.
- Then -> TRIG if auto_en=1, else -> IDLE.
- start SHALL be ignored in every state except IDLE.
REQ-016 dist_valid and timeout SHALL never assert in the same cycle.

Reset
REQ-017 rst=1 SHALL immediately force: state IDLE; trig, busy, dist_valid and timeout to 0; dist_mm to 0; all counters and synchronizer flops to 0.
REQ-018 A reset mid-cycle SHALL drop trig asynchronously; no dist_valid or timeout pulse is produced for the aborted cycle.

Configuration
REQ-019 With ECHO_DEGLITCH_EN defined, echo_s SHALL change only after the synchronized echo holds a new value for 4 consecutive clocks; pulses shorter than 4 clocks are ignored.
REQ-020 Without ECHO_DEGLITCH_EN, echo_s SHALL be the 2-flop synchronizer output directly, adding 2 cycles of latency.

Structure
REQ-021 The shared package hcsr04_pkg SHALL hold:
- the state enum typedef;
- the constant DIST_SCALE = 11239;
- the constant DIST_SHIFT = 16.
REQ-022 The us prescaler SHALL be the sub-module us_tick_gen, with ports clk, rst, clr and tick.

Verification
REQ-023 Bench SHALL run at CLKS_PER_US=50 and cover:
- start pulse in IDLE -> trig high for exactly 500 cycles; busy=1 from the next cycle.
- echo high for 1000 us, 300 us after trig falls -> one dist_valid pulse with dist_mm=171, then 60000 us HOLDOFF, then IDLE with busy=0.
- no echo -> timeout pulse 2000 us after trig falls; dist_mm keeps its previous value.
- echo held high for more than 38000 us -> timeout pulse at 38000 us; no dist_valid.
- auto_en=1, echo 2915 us -> dist_mm=499 each cycle; trig rising edges are 60000 us plus cycle length apart; start pulses during busy are ignored.
- rst asserted mid-MEASURE -> trig=0 and all outputs 0 within the same cycle; no pulse; a fresh start works.
